// File: rtl/hamming_pkg.sv
// hamming_pkg: bit layout, syndrome and result types shared by the SECDED encoder, decoder and benches
package hamming_pkg;
  localparam int POS_PG = 0;
  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_D1 = 3;
  localparam int POS_P3 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;
  localparam int POS_D4 = 7;
  typedef logic [2:0] sindrome_t;
  typedef struct packed {
    logic [3:0] dato;
    sindrome_t  posicion;
    logic       simple;
    logic       doble;
  } resultado_t;
  function automatic sindrome_t calcular_sindrome(input logic [7:0] w);
    return {w[POS_P3] ^ w[POS_D2] ^ w[POS_D3] ^ w[POS_D4],
            w[POS_P2] ^ w[POS_D1] ^ w[POS_D3] ^ w[POS_D4],
            w[POS_P1] ^ w[POS_D1] ^ w[POS_D2] ^ w[POS_D4]};
  endfunction
endpackage

// File: rtl/hamming_clasificador.sv
// hamming_clasificador: turns a codeword with its syndrome and global parity into corrected data and status
module hamming_clasificador
  import hamming_pkg::*;
(
  input  logic [7:0] palabra,
  input  sindrome_t  sindrome,
  input  logic       paridad,
  output resultado_t resultado
);
  logic [7:0] corregida;
  logic       hay_sindrome;
  assign hay_sindrome = sindrome != 3'd0;
  // only odd overall parity means a correctable error; a double error keeps the raw data
  assign corregida = palabra ^ ((paridad && hay_sindrome) ? (8'd1 << sindrome) : 8'd0);
  assign resultado = '{
    dato:     {corregida[POS_D4], corregida[POS_D3], corregida[POS_D2], corregida[POS_D1]},
    posicion: sindrome,
    simple:   paridad,
    doble:    !paridad && hay_sindrome
  };
endmodule

// File: rtl/decodificador_hamming.sv
// decodificador_hamming: two-stage SECDED (7,4)+parity decoder with valid/ready flow and saturating error counters
module decodificador_hamming
  import hamming_pkg::*;
#(
  parameter int ANCHO_CONT = 8
) (
  input  logic                  reloj,
  input  logic                  reset_n,
  input  logic [7:0]            palabra_entrada,
  input  logic                  valido_entrada,
  output logic                  listo_entrada,
  output logic [3:0]            dato_salida,
  output logic [2:0]            posicion_error,
  output logic                  error_simple,
  output logic                  error_doble,
  output logic                  valido_salida,
  input  logic                  listo_salida,
  input  logic                  limpiar_contadores,
  output logic [ANCHO_CONT-1:0] cuenta_simple,
  output logic [ANCHO_CONT-1:0] cuenta_doble
);
  logic                  v1_q, v1_d, v2_q, v2_d, pg_q, pg_d;
  logic [7:0]            palabra_q, palabra_d;
  sindrome_t             sindrome_q, sindrome_d;
  resultado_t            res_q, res_d, res_c;
  logic [ANCHO_CONT-1:0] cs_q, cs_d, cd_q, cd_d;
  logic                  carga1, carga2, entrega;
  assign listo_entrada = !v1_q || !v2_q || listo_salida;
  assign carga1        = valido_entrada && listo_entrada;
  assign carga2        = v1_q && (!v2_q || listo_salida);
  assign entrega       = v2_q && listo_salida;
  hamming_clasificador u_clasificador (
    .palabra   (palabra_q),
    .sindrome  (sindrome_q),
    .paridad   (pg_q),
    .resultado (res_c)
  );
  always_comb begin
    v1_d       = carga1 ? 1'b1 : (carga2 ? 1'b0 : v1_q);
    v2_d       = carga2 ? 1'b1 : (entrega ? 1'b0 : v2_q);
    palabra_d  = carga1 ? palabra_entrada : palabra_q;
    sindrome_d = carga1 ? calcular_sindrome(palabra_entrada) : sindrome_q;
    pg_d       = carga1 ? ^palabra_entrada : pg_q;
    res_d      = carga2 ? res_c : res_q;
    cs_d       = limpiar_contadores ? '0 : (entrega && res_q.simple && !(&cs_q)) ? cs_q + ANCHO_CONT'(1) : cs_q;
    cd_d       = limpiar_contadores ? '0 : (entrega && res_q.doble && !(&cd_q)) ? cd_q + ANCHO_CONT'(1) : cd_q;
  end
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      palabra_q  <= '0;
      sindrome_q <= '0;
      pg_q       <= 1'b0;
      res_q      <= '0;
      cs_q       <= '0;
      cd_q       <= '0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      palabra_q  <= palabra_d;
      sindrome_q <= sindrome_d;
      pg_q       <= pg_d;
      res_q      <= res_d;
      cs_q       <= cs_d;
      cd_q       <= cd_d;
    end
  end
  assign valido_salida  = v2_q;
  assign dato_salida    = res_q.dato;
  assign posicion_error = res_q.posicion;
  assign error_simple   = res_q.simple;
  assign error_doble    = res_q.doble;
  assign cuenta_simple  = cs_q;
  assign cuenta_doble   = cd_q;
endmodule

// File: tb/tb_decodificador_hamming.sv
// tb_decodificador_hamming: directed vectors with hand-computed results for the SECDED decoder
module tb_decodificador_hamming;
  logic       reloj = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] palabra_entrada = 8'h00;
  logic       valido_entrada = 1'b0;
  logic       listo_entrada;
  logic [3:0] dato_salida;
  logic [2:0] posicion_error;
  logic       error_simple, error_doble, valido_salida;
  logic       listo_salida = 1'b1;
  logic       limpiar_contadores = 1'b0;
  logic [7:0] cuenta_simple, cuenta_doble;
  int total = 0;
  int bad = 0;
  always #5 reloj = ~reloj;
  decodificador_hamming #(.ANCHO_CONT(8)) dut (
    .reloj              (reloj),
    .reset_n            (reset_n),
    .palabra_entrada    (palabra_entrada),
    .valido_entrada     (valido_entrada),
    .listo_entrada      (listo_entrada),
    .dato_salida        (dato_salida),
    .posicion_error     (posicion_error),
    .error_simple       (error_simple),
    .error_doble        (error_doble),
    .valido_salida      (valido_salida),
    .listo_salida       (listo_salida),
    .limpiar_contadores (limpiar_contadores),
    .cuenta_simple      (cuenta_simple),
    .cuenta_doble       (cuenta_doble)
  );
  task automatic tick();
    @(posedge reloj);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic result(input string tag, input logic [3:0] d, input logic [2:0] p, input logic s, input logic e2);
    chk({tag, "_valid"}, 32'(valido_salida), 32'd1);
    chk({tag, "_dato"}, 32'(dato_salida), 32'(d));
    chk({tag, "_pos"}, 32'(posicion_error), 32'(p));
    chk({tag, "_simple"}, 32'(error_simple), 32'(s));
    chk({tag, "_doble"}, 32'(error_doble), 32'(e2));
  endtask
  task automatic send(input logic [7:0] w);
    palabra_entrada = w;
    valido_entrada = 1'b1;
    tick();
    valido_entrada = 1'b0;
    chk("lat_not_early", 32'(valido_salida), 32'd0);
    tick();
  endtask
  initial begin
    tick();
    tick();
    chk("rst_valid", 32'(valido_salida), 32'd0);
    chk("rst_listo", 32'(listo_entrada), 32'd1);
    chk("rst_dato", 32'(dato_salida), 32'd0);
    chk("rst_pos", 32'(posicion_error), 32'd0);
    chk("rst_flags", 32'({error_simple, error_doble}), 32'd0);
    chk("rst_cnt", 32'({cuenta_simple, cuenta_doble}), 32'd0);
    reset_n = 1'b1;
    tick();
    send(8'hAA);
    result("clean", 4'b1011, 3'd0, 1'b0, 1'b0);
    tick();
    chk("clean_cnt_s", 32'(cuenta_simple), 32'd0);
    chk("clean_drained", 32'(valido_salida), 32'd0);
    send(8'h8A);
    result("single5", 4'b1011, 3'd5, 1'b1, 1'b0);
    tick();
    chk("single5_cnt_s", 32'(cuenta_simple), 32'd1);
    send(8'hAB);
    result("par0", 4'b1011, 3'd0, 1'b1, 1'b0);
    tick();
    chk("par0_cnt_s", 32'(cuenta_simple), 32'd2);
    send(8'h82);
    result("double", 4'b1000, 3'd6, 1'b0, 1'b1);
    tick();
    chk("double_cnt_d", 32'(cuenta_doble), 32'd1);
    chk("double_cnt_s", 32'(cuenta_simple), 32'd2);
    listo_salida = 1'b0;
    palabra_entrada = 8'hAA;
    valido_entrada = 1'b1;
    tick();
    palabra_entrada = 8'h8A;
    chk("bp_listo_1", 32'(listo_entrada), 32'd1);
    tick();
    palabra_entrada = 8'hAB;
    chk("bp_listo_drop", 32'(listo_entrada), 32'd0);
    tick();
    result("bp_hold1", 4'b1011, 3'd0, 1'b0, 1'b0);
    tick();
    result("bp_hold2", 4'b1011, 3'd0, 1'b0, 1'b0);
    chk("bp_listo_hold", 32'(listo_entrada), 32'd0);
    listo_salida = 1'b1;
    tick();
    valido_entrada = 1'b0;
    result("bp_out2", 4'b1011, 3'd5, 1'b1, 1'b0);
    chk("bp_cnt_a", 32'(cuenta_simple), 32'd2);
    tick();
    result("bp_out3", 4'b1011, 3'd0, 1'b1, 1'b0);
    chk("bp_cnt_b", 32'(cuenta_simple), 32'd3);
    tick();
    chk("bp_empty", 32'(valido_salida), 32'd0);
    chk("bp_cnt_c", 32'(cuenta_simple), 32'd4);
    limpiar_contadores = 1'b1;
    tick();
    limpiar_contadores = 1'b0;
    chk("clr_s", 32'(cuenta_simple), 32'd0);
    chk("clr_d", 32'(cuenta_doble), 32'd0);
    palabra_entrada = 8'h8A;
    valido_entrada = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 255) chk("sat_255_reached", 32'(cuenta_simple), 32'd254);
    end
    valido_entrada = 1'b0;
    tick();
    tick();
    tick();
    chk("sat_s", 32'(cuenta_simple), 32'd255);
    chk("sat_d", 32'(cuenta_doble), 32'd0);
    listo_salida = 1'b0;
    send(8'h8A);
    listo_salida = 1'b1;
    limpiar_contadores = 1'b1;
    tick();
    limpiar_contadores = 1'b0;
    chk("clr_hs_cnt", 32'(cuenta_simple), 32'd0);
    chk("clr_hs_valid", 32'(valido_salida), 32'd0);
    palabra_entrada = 8'hAA;
    valido_entrada = 1'b1;
    tick();
    tick();
    chk("ar_pre_valid", 32'(valido_salida), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(valido_salida), 32'd0);
    chk("ar_dato", 32'(dato_salida), 32'd0);
    chk("ar_listo", 32'(listo_entrada), 32'd1);
    valido_entrada = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("ar_no_partial", 32'(valido_salida), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
